// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   A chain of DEPTH pipeline registers with valid/ready flow control. It
//   supports a per-stage squash (kill), a global flush and bubble collapse,
//   where an entry advances into an empty or killed stage even while the
//   output is stalled. Every stage's valid bit and payload are exported so that
//   hazard and forwarding logic can inspect them.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     upstream presents in_data
//   in_ready     stage 0 accepts this cycle
//   in_data      payload into stage 0
//   out_valid    stage DEPTH-1 holds a live entry
//   out_ready    downstream accepts out_data
//   out_data     payload of stage DEPTH-1
//   kill         per-stage squash, bit i = stage i
//   flush        squash all stages and drop this cycle's input
//   stage_valid  registered valid bit of each stage
//   stage_data   stage i payload at [i*WIDTH +: WIDTH]
//   occupancy    registered count of live stages
module pipe_stage_chain #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  input  logic [DEPTH-1:0]       kill,
  input  logic                   flush,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CNT_W-1:0]       occupancy
);

  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [CNT_W-1:0] occ_reg;
  logic [CNT_W-1:0] occ_next;

  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [CNT_W-1:0] killed_cnt;
  logic             accept;
  logic             deliver;
  logic             chain_load;

  // What each stage would capture if it loads this cycle.
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];

  // Ready chain, walked from the output end back to the input end. Held in a
  // single process so the stage-to-stage dependency is a plain ripple. A
  // flushed stage counts as not live, so every stage loads "nothing" on a
  // flush and all valid bits clear without a separate flush path.
  always_comb begin
    live       = '0;
    move       = '0;
    load       = '0;
    killed_cnt = '0;
    chain_load = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      live[i]    = valid_reg[i] & ~kill[i] & ~flush;
      move[i]    = live[i] & chain_load;
      load[i]    = ~live[i] | move[i];
      chain_load = load[i];
      if (valid_reg[i] && kill[i] && !flush) begin
        killed_cnt = killed_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready = load[0] & ~flush & reset;
  assign accept   = in_valid & in_ready;
  assign deliver  = move[DEPTH-1];

  // Count update never underflows or overflows because each term matches a
  // distinct entry entering or leaving the chain.
  always_comb begin
    occ_next = occ_reg + CNT_W'(accept) - CNT_W'(deliver) - killed_cnt;
    if (flush) begin
      occ_next = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign src_valid[gi] = accept;
        assign src_data[gi]  = in_data;
      end else begin : g_body
        assign src_valid[gi] = move[gi-1];
        assign src_data[gi]  = data_reg[gi-1];
      end
      assign stage_data[gi*WIDTH +: WIDTH] = data_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      occ_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      occ_reg <= occ_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          valid_reg[i] <= src_valid[i];
          // Payload is only rewritten when a real entry arrives; a bubble
          // leaves the stale bits in place.
          if (src_valid[i]) begin
            data_reg[i] <= src_data[i];
          end
        end
      end
    end
  end

  assign out_valid   = live[DEPTH-1];
  assign out_data    = data_reg[DEPTH-1];
  assign stage_valid = valid_reg;
  assign occupancy   = occ_reg;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain
//   Directed stimulus for pipe_stage_chain (DEPTH=4, WIDTH=32). The stimulus
//   process pushes hand-computed expected output words into a queue; a
//   separate monitor pops and compares on every output handshake.
module tb_pipe_stage_chain;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [DEPTH-1:0]       kill;
  logic                   flush;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [CNT_W-1:0]       occupancy;

  int compared   = 0;
  int mismatched = 0;
  logic [WIDTH-1:0] exp_q [$];

  pipe_stage_chain #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .kill        (kill),
    .flush       (flush),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever both
  // handshake signals are high at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_output got %0h want none", out_data);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            mismatched++;
            $display("FAIL out_data got %0h want %0h", out_data, e);
          end else begin
            $display("ok   out_data = %0h", out_data);
          end
        end
      end
    end
  end

  // Watchdog: the stimulus below is a fixed number of cycles.
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic fill4(input logic [WIDTH-1:0] base);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = base + WIDTH'(k);
      step(1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    kill      = '0;
    flush     = 1'b0;

    // Reset state
    step(2);
    check("rst_stage_valid", 128'(stage_valid), 128'h0);
    check("rst_occupancy", 128'(occupancy), 128'h0);
    check("rst_out_valid", 128'(out_valid), 128'h0);
    check("rst_in_ready", 128'(in_ready), 128'h0);
    reset = 1'b1;
    step(1);

    // 1: streaming, latency DEPTH, throughput 1/cycle
    for (int k = 1; k <= 8; k++) exp_q.push_back(WIDTH'(k));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = WIDTH'(k);
      step(1);
      if (k == 3) check("lat_not_yet", 128'(out_valid), 128'h0);
      if (k == 4) begin
        check("lat_out_valid", 128'(out_valid), 128'h1);
        check("lat_out_data", 128'(out_data), 128'h1);
      end
    end
    check("stream_occupancy", 128'(occupancy), 128'h4);
    in_valid = 1'b0;
    step(6);
    check("drain1_occupancy", 128'(occupancy), 128'h0);

    // 2: full chain stalls and freezes
    fill4(32'd11);
    check("full_occupancy", 128'(occupancy), 128'h4);
    in_valid = 1'b1;
    in_data  = 32'd15;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("full_in_ready", 128'(in_ready), 128'h0);
      check("full_stage_data", 128'(stage_data), {32'd11, 32'd12, 32'd13, 32'd14});
      step(1);
    end
    in_valid = 1'b0;
    for (int k = 11; k <= 14; k++) exp_q.push_back(WIDTH'(k));
    out_ready = 1'b1;
    step(6);
    check("drain2_occupancy", 128'(occupancy), 128'h0);

    // 3: bubble collapse with output stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd21;
    step(1);
    in_valid = 1'b0;
    step(3);
    in_valid = 1'b1;
    in_data  = 32'd22;
    step(1);
    in_valid = 1'b0;
    check("gap_stage_valid", 128'(stage_valid), 128'h9);
    check("gap_occupancy", 128'(occupancy), 128'h2);
    step(2);
    check("collapse_stage_valid", 128'(stage_valid), 128'hC);
    check("collapse_stage2", 128'(stage_data[2*WIDTH +: WIDTH]), 128'd22);
    check("collapse_occupancy", 128'(occupancy), 128'h2);
    exp_q.push_back(32'd21);
    exp_q.push_back(32'd22);
    out_ready = 1'b1;
    step(5);

    // 4: kill stage 2 while draining and accepting
    fill4(32'd31);
    exp_q.push_back(32'd31);
    exp_q.push_back(32'd33);
    exp_q.push_back(32'd34);
    exp_q.push_back(32'd35);
    out_ready = 1'b1;
    kill      = 4'b0100;
    in_valid  = 1'b1;
    in_data   = 32'd35;
    step(1);
    kill     = '0;
    in_valid = 1'b0;
    check("kill_stage_valid", 128'(stage_valid), 128'h7);
    check("kill_stage2", 128'(stage_data[2*WIDTH +: WIDTH]), 128'd33);
    check("kill_occupancy", 128'(occupancy), 128'h3);
    step(6);
    check("drain4_occupancy", 128'(occupancy), 128'h0);

    // 5: flush overrides everything, 0xAA is dropped
    fill4(32'd41);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hAA;
    out_ready = 1'b1;
    #1;
    check("flush_in_ready", 128'(in_ready), 128'h0);
    check("flush_out_valid", 128'(out_valid), 128'h0);
    step(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_stage_valid", 128'(stage_valid), 128'h0);
    check("flush_occupancy", 128'(occupancy), 128'h0);
    step(6);

    // 6: asynchronous reset pulse mid-cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd51;
    step(1);
    in_data = 32'd52;
    step(1);
    in_valid = 1'b0;
    check("pre_reset_occupancy", 128'(occupancy), 128'h2);
    #2;
    reset = 1'b0;
    #1;
    check("async_stage_valid", 128'(stage_valid), 128'h0);
    check("async_occupancy", 128'(occupancy), 128'h0);
    check("async_in_ready", 128'(in_ready), 128'h0);
    #3;
    reset = 1'b1;
    step(1);
    exp_q.push_back(32'd61);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd61;
    step(1);
    in_valid = 1'b0;
    step(6);
    check("final_occupancy", 128'(occupancy), 128'h0);
    check("queue_empty", 128'(exp_q.size()), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
